// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t : FSM state encoding (IDLE / CALC / FIX)
//   cw_of   : iteration counter width for an N-bit divider
//   neg_n   : two's-complement negation on a MAXW-bit container
//   abs_n   : conditional negation (magnitude when the sign flag is set)
// Callers zero-extend N-bit values to MAXW bits and truncate the result back
// to N bits; the low N bits of a wide negation equal the N-bit negation.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int unsigned MAXW = 128;

  function automatic int cw_of(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic logic [MAXW-1:0] neg_n(input logic [MAXW-1:0] x);
    return ~x + MAXW'(1);
  endfunction

  function automatic logic [MAXW-1:0] abs_n(input logic [MAXW-1:0] x, input logic is_neg);
    return is_neg ? neg_n(x) : x;
  endfunction

endpackage

// File: rtl/seq_division_generic_if.sv
// Request/result bundle for seq_division_generic.
//   master : requester drives start, signed_mode, Dividend, Divisor
//   slave  : divider drives busy, done, Quotient, Reminder, div_by_zero, overflow
interface seq_division_generic_if #(
  parameter int N = 24
);
  logic         start;
  logic         signed_mode;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] Quotient;
  logic [N-1:0] Reminder;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, signed_mode, Dividend, Divisor,
    input  busy, done, Quotient, Reminder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, Dividend, Divisor,
    output busy, done, Quotient, Reminder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_division_generic_div_step.sv
// One restoring radix-2 division step (combinational).
//   rem_in  : current (N+1)-bit partial remainder
//   divisor : N-bit divisor magnitude
//   bit_in  : next dividend bit, shifted in at the LSB
//   rem_out : next partial remainder (restored when the trial goes negative)
//   q_bit   : quotient bit, 1 when the trial subtraction is non-negative
module div_step #(
  parameter int N = 24
) (
  input  logic [N:0]   rem_in,
  input  logic [N-1:0] divisor,
  input  logic         bit_in,
  output logic [N:0]   rem_out,
  output logic         q_bit
);
  // One extra bit above the shifted value so the borrow lands in diff[N+1].
  logic [N+1:0] shifted;
  logic [N+1:0] diff;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[N+1];
  assign rem_out = q_bit ? diff[N:0] : shifted[N:0];
endmodule

// File: rtl/seq_division_generic.sv
// Multi-cycle restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any operation, no done)
//   bus   : slave side of seq_division_generic_if (start/operands in,
//           busy/done/results/flags out)
// Normal operations raise done N+1 cycles after acceptance; divide-by-zero
// and signed overflow skip CALC and finish on the edge after acceptance.
//
// state | meaning
// IDLE  | waiting for start; busy low
// CALC  | N shift/trial-subtract steps on operand magnitudes
// FIX   | apply signs or special-case results, pulse done
module seq_division_generic
  import div_pkg::*;
#(
  parameter  int N  = 24,
  localparam int CW = cw_of(N)
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_division_generic_if.slave bus
);

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  state_t       state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N:0]   prem;
  logic [N-1:0] qsh;       // dividend magnitude, becomes quotient magnitude
  logic [N-1:0] dvs;
  logic [N-1:0] dvd_orig;
  logic         neg_q, neg_r, zero_f, ovf_f;

  logic         dvd_neg, dvs_neg, in_zero, in_ovf;
  logic [N-1:0] dvd_abs, dvs_abs, q_fix, r_fix;
  logic [N:0]   prem_nxt;
  logic         q_bit;

  always_comb begin
    dvd_neg = bus.signed_mode & bus.Dividend[N-1];
    dvs_neg = bus.signed_mode & bus.Divisor[N-1];
    dvd_abs = N'(abs_n(MAXW'(bus.Dividend), dvd_neg));
    dvs_abs = N'(abs_n(MAXW'(bus.Divisor), dvs_neg));
    in_zero = (bus.Divisor == '0);
    in_ovf  = bus.signed_mode && (bus.Dividend == MOST_NEG) && (&bus.Divisor);
    q_fix   = neg_q ? N'(neg_n(MAXW'(qsh))) : qsh;
    r_fix   = neg_r ? N'(neg_n(MAXW'(prem[N-1:0]))) : prem[N-1:0];
  end

  div_step #(.N(N)) u_step (
    .rem_in  (prem),
    .divisor (dvs),
    .bit_in  (qsh[N-1]),
    .rem_out (prem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (in_zero || in_ovf) ? FIX : CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      prem            <= '0;
      qsh             <= '0;
      dvs             <= '0;
      dvd_orig        <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      zero_f          <= 1'b0;
      ovf_f           <= 1'b0;
      bus.done        <= 1'b0;
      bus.Quotient    <= '0;
      bus.Reminder    <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_q           <= dvd_neg ^ dvs_neg;
            neg_r           <= dvd_neg;
            dvd_orig        <= bus.Dividend;
            qsh             <= dvd_abs;
            dvs             <= dvs_abs;
            prem            <= '0;
            cnt             <= CW'(N - 1);
            zero_f          <= in_zero;
            ovf_f           <= in_ovf & ~in_zero;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
          end
        end
        CALC: begin
          prem <= prem_nxt;
          qsh  <= {qsh[N-2:0], q_bit};
          cnt  <= cnt - CW'(1);
        end
        FIX: begin
          bus.done        <= 1'b1;
          bus.div_by_zero <= zero_f;
          bus.overflow    <= ovf_f;
          if (zero_f) begin
            bus.Quotient <= '1;
            bus.Reminder <= dvd_orig;
          end else if (ovf_f) begin
            bus.Quotient <= MOST_NEG;
            bus.Reminder <= '0;
          end else begin
            bus.Quotient <= q_fix;
            bus.Reminder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_division_generic.sv
`timescale 1ns/1ps
module tb_seq_division_generic;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seq_division_generic_if #(.N(8))  if8();
  seq_division_generic_if #(.N(24)) if24();

  seq_division_generic #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  seq_division_generic #(.N(24)) dut24 (.clk(clk), .rst_n(rst_n), .bus(if24));

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: truncating / and % on sign-interpreted operands.
  function automatic void ref_div(input int w, input logic sm, input logic [23:0] a, b,
                                  output logic [23:0] q, r, output logic z, o);
    longint sa, sb, mask, lq, lr;
    logic [23:0] mn, ones;
    mask = (longint'(1) << w) - 1;
    ones = mask[23:0];
    mn   = 24'(longint'(1) << (w - 1));
    z = 1'b0; o = 1'b0;
    if (b == 24'd0) begin
      z = 1'b1; q = ones; r = a;
    end else if (sm && a == mn && b == ones) begin
      o = 1'b1; q = mn; r = 24'd0;
    end else begin
      if (sm) begin
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      lq = sa / sb;
      lr = sa % sb;
      q = 24'(lq & mask);
      r = 24'(lr & mask);
    end
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? if8.done : if24.done;
  endfunction

  // Drives one request, returns results and the edge count from acceptance to done (-1 on timeout).
  task automatic op(input int w, input logic sm, input logic [23:0] a, b,
                    output logic [23:0] q, r, output logic z, o, output int lat);
    @(negedge clk);
    if (w == 8) begin
      if8.start = 1'b1; if8.signed_mode = sm; if8.Dividend = a[7:0]; if8.Divisor = b[7:0];
    end else begin
      if24.start = 1'b1; if24.signed_mode = sm; if24.Dividend = a; if24.Divisor = b;
    end
    @(posedge clk); #1;
    if8.start = 1'b0; if24.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (get_done(w)) begin lat = i; break; end
    end
    if (w == 8) begin
      q = {16'd0, if8.Quotient}; r = {16'd0, if8.Reminder}; z = if8.div_by_zero; o = if8.overflow;
    end else begin
      q = if24.Quotient; r = if24.Reminder; z = if24.div_by_zero; o = if24.overflow;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if8.start = 0; if8.signed_mode = 0; if8.Dividend = 0; if8.Divisor = 0;
    if24.start = 0; if24.signed_mode = 0; if24.Dividend = 0; if24.Divisor = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if8.busy, if8.done, if8.Quotient, if8.Reminder, if8.div_by_zero, if8.overflow} !== 20'd0) begin
      n_fail++; $display("FAIL reset8: got busy=%b done=%b q=%h r=%h z=%b o=%b expected all 0",
        if8.busy, if8.done, if8.Quotient, if8.Reminder, if8.div_by_zero, if8.overflow);
    end
    n_checks++;
    if ({if24.busy, if24.done, if24.Quotient, if24.Reminder, if24.div_by_zero, if24.overflow} !== 52'd0) begin
      n_fail++; $display("FAIL reset24: got busy=%b done=%b q=%h r=%h z=%b o=%b expected all 0",
        if24.busy, if24.done, if24.Quotient, if24.Reminder, if24.div_by_zero, if24.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned24();
    logic [23:0] q, r; logic z, o; int lat;
    op(24, 1'b0, 24'h7E1000, 24'h078000, q, r, z, o, lat);
    n_checks++;
    if (q !== 24'h000010) begin n_fail++; $display("FAIL u24_quot: got %h expected 000010", q); end
    n_checks++;
    if (r !== 24'h061000) begin n_fail++; $display("FAIL u24_rem: got %h expected 061000", r); end
    n_checks++;
    if ({z, o} !== 2'b00) begin n_fail++; $display("FAIL u24_flags: got z=%b o=%b expected 0 0", z, o); end
    n_checks++;
    if (lat !== 25) begin n_fail++; $display("FAIL u24_latency: got %0d expected 25", lat); end
    n_checks++;
    if (if24.busy !== 1'b0) begin n_fail++; $display("FAIL u24_busy_at_done: got %b expected 0", if24.busy); end
  endtask

  task automatic test_signed8();
    logic [23:0] q, r; logic z, o; int lat;
    op(8, 1'b1, 24'hF9, 24'h02, q, r, z, o, lat);
    n_checks++;
    if ({q[7:0], r[7:0]} !== 16'hFDFF) begin n_fail++; $display("FAIL s8_neg7_div2: got q=%h r=%h expected q=fd r=ff", q[7:0], r[7:0]); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL s8_latency: got %0d expected 9", lat); end
    op(8, 1'b1, 24'h07, 24'hFE, q, r, z, o, lat);
    n_checks++;
    if ({q[7:0], r[7:0]} !== 16'hFD01) begin n_fail++; $display("FAIL s8_7_divneg2: got q=%h r=%h expected q=fd r=01", q[7:0], r[7:0]); end
    op(8, 1'b1, 24'h80, 24'h03, q, r, z, o, lat);
    n_checks++;
    if ({q[7:0], r[7:0], z, o} !== 18'b11010110_11111110_00) begin
      n_fail++; $display("FAIL s8_neg128_div3: got q=%h r=%h z=%b o=%b expected q=d6 r=fe z=0 o=0", q[7:0], r[7:0], z, o);
    end
  endtask

  task automatic test_special8();
    logic [23:0] q, r; logic z, o; int lat;
    op(8, 1'b0, 24'd100, 24'd0, q, r, z, o, lat);
    n_checks++;
    if ({q[7:0], r[7:0], z, o} !== {8'hFF, 8'h64, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL div_zero: got q=%h r=%h z=%b o=%b expected q=ff r=64 z=1 o=0", q[7:0], r[7:0], z, o);
    end
    // Divide-by-zero goes straight to FIX, so done follows the edge after acceptance.
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL div_zero_latency: got %0d expected 1", lat); end
    op(8, 1'b1, 24'hFB, 24'd0, q, r, z, o, lat);
    n_checks++;
    if ({q[7:0], r[7:0], z} !== {8'hFF, 8'hFB, 1'b1}) begin
      n_fail++; $display("FAIL div_zero_signed: got q=%h r=%h z=%b expected q=ff r=fb z=1", q[7:0], r[7:0], z);
    end
    op(8, 1'b1, 24'h80, 24'hFF, q, r, z, o, lat);
    n_checks++;
    if ({q[7:0], r[7:0], z, o} !== {8'h80, 8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL overflow: got q=%h r=%h z=%b o=%b expected q=80 r=00 z=0 o=1", q[7:0], r[7:0], z, o);
    end
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL overflow_latency: got %0d expected 1", lat); end
    op(8, 1'b0, 24'h80, 24'hFF, q, r, z, o, lat);
    n_checks++;
    if ({q[7:0], r[7:0], z, o} !== {8'h00, 8'h80, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL unsigned_no_ovf: got q=%h r=%h z=%b o=%b expected q=00 r=80 z=0 o=0", q[7:0], r[7:0], z, o);
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0, lat = -1;
    logic [7:0] q = 0, r = 0;
    @(negedge clk);
    if8.start = 1'b1; if8.signed_mode = 1'b0; if8.Dividend = 8'd200; if8.Divisor = 8'd7;
    @(posedge clk); #1;
    if8.start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin
        if8.start = 1'b1; if8.signed_mode = 1'b1; if8.Dividend = 8'd50; if8.Divisor = 8'd5;
      end
      if (i == 5) if8.start = 1'b0;
      if (if8.done) begin
        ndone++;
        if (lat < 0) begin lat = i; q = if8.Quotient; r = if8.Reminder; end
      end
    end
    n_checks++;
    if (ndone !== 1) begin n_fail++; $display("FAIL ignore_start_count: got %0d done pulses expected 1", ndone); end
    n_checks++;
    if ({q, r} !== {8'h1C, 8'h04}) begin n_fail++; $display("FAIL ignore_start_result: got q=%h r=%h expected q=1c r=04", q, r); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL ignore_start_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, ndone = 0;
    logic [7:0] q1 = 0, r1 = 0, q2 = 0, r2 = 0;
    @(negedge clk);
    if8.start = 1'b1; if8.signed_mode = 1'b0; if8.Dividend = 8'd45; if8.Divisor = 8'd6;
    @(posedge clk); #1;
    // Held start with new operands: ignored while busy, accepted at the end of the done cycle.
    if8.Dividend = 8'd250; if8.Divisor = 8'd16;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (d1 >= 0 && i == d1 + 1) if8.start = 1'b0;
      if (if8.done) begin
        ndone++;
        if (d1 < 0) begin d1 = i; q1 = if8.Quotient; r1 = if8.Reminder; end
        else begin d2 = i; q2 = if8.Quotient; r2 = if8.Reminder; end
      end
    end
    if8.start = 1'b0;
    n_checks++;
    if ({q1, r1} !== {8'h07, 8'h03}) begin n_fail++; $display("FAIL b2b_first: got q=%h r=%h expected q=07 r=03", q1, r1); end
    n_checks++;
    if ({q2, r2} !== {8'h0F, 8'h0A}) begin n_fail++; $display("FAIL b2b_second: got q=%h r=%h expected q=0f r=0a", q2, r2); end
    n_checks++;
    if (ndone !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d done pulses expected 2", ndone); end
    // N+1 cycles between the pulses -> the second done is N+2 edges after the first.
    n_checks++;
    if (d2 - d1 !== 10) begin n_fail++; $display("FAIL b2b_spacing: got %0d edges expected 10", d2 - d1); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] q, r; logic z, o; int lat, ndone = 0;
    @(negedge clk);
    if8.start = 1'b1; if8.signed_mode = 1'b0; if8.Dividend = 8'd200; if8.Divisor = 8'd7;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({if8.busy, if8.done, if8.Quotient, if8.Reminder, if8.div_by_zero, if8.overflow} !== 20'd0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h z=%b o=%b expected all 0",
        if8.busy, if8.done, if8.Quotient, if8.Reminder, if8.div_by_zero, if8.overflow);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (if8.done) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", ndone); end
    op(8, 1'b0, 24'd93, 24'd10, q, r, z, o, lat);
    n_checks++;
    if ({q[7:0], r[7:0], lat} !== {8'h09, 8'h03, 32'd9}) begin
      n_fail++; $display("FAIL reset_mid_restart: got q=%h r=%h lat=%0d expected q=09 r=03 lat=9", q[7:0], r[7:0], lat);
    end
  endtask

  task automatic test_random(input int w, input int count);
    logic [23:0] a, b, q, r, eq, er, mask;
    logic z, o, ez, eo, sm;
    int lat, elat, bad = 0;
    mask = (w == 8) ? 24'h0000FF : 24'hFFFFFF;
    for (int i = 0; i < count; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = 24'($urandom) & mask;
      b  = 24'($urandom) & mask;
      case ($urandom_range(0, 19))
        0: b = 24'($urandom_range(0, 2));
        1: begin a = (mask >> 1) + 24'd1; b = mask; end
        2: b = b >> $urandom_range(1, w - 1);
        default: ;
      endcase
      ref_div(w, sm, a, b, eq, er, ez, eo);
      elat = (ez || eo) ? 1 : w + 1;
      op(w, sm, a, b, q, r, z, o, lat);
      n_checks++;
      if ({q, r, z, o, lat} !== {eq, er, ez, eo, elat}) begin
        n_fail++; bad++;
        if (bad <= 10)
          $display("FAIL random%0d: sm=%b a=%h b=%h got q=%h r=%h z=%b o=%b lat=%0d expected q=%h r=%h z=%b o=%b lat=%0d",
            w, sm, a, b, q, r, z, o, lat, eq, er, ez, eo, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned24();
    test_signed8();
    test_special8();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random(8, 1000);
    test_random(24, 1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
